mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 67 ++++++
 rtl/mc_ctrl_outdec.sv | 87 ++++++++
 rtl/mc_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mc_controller_pkg.sv
// -----------------------------------------------------------------------------
// mc_controller_pkg
// Shared definitions for the multicycle controller: instruction opcodes
// (EXE_*), FSM state encoding, the packed control word driven by the output
// decoder, and an opcode legality helper.
// -----------------------------------------------------------------------------
package mc_controller_pkg;

   // Opcodes (instruction bits [31:26])
   localparam logic [5:0] EXE_RTYPE = 6'b000000;
   localparam logic [5:0] EXE_J     = 6'b000010;
   localparam logic [5:0] EXE_BEQ   = 6'b000100;
   localparam logic [5:0] EXE_ADDI  = 6'b001000;
   localparam logic [5:0] EXE_ADDIU = 6'b001001;
   localparam logic [5:0] EXE_SLTI  = 6'b001010;
   localparam logic [5:0] EXE_SLTIU = 6'b001011;
   localparam logic [5:0] EXE_ANDI  = 6'b001100;
   localparam logic [5:0] EXE_ORI   = 6'b001101;
   localparam logic [5:0] EXE_XORI  = 6'b001110;
   localparam logic [5:0] EXE_LUI   = 6'b001111;
   localparam logic [5:0] EXE_LW    = 6'b100011;
   localparam logic [5:0] EXE_SW    = 6'b101011;

   // FSM states; FETCH is 0 so a forced-zero debug output still reads FETCH.
   typedef enum logic [3:0] {
      ST_FETCH   = 4'd0,
      ST_DECODE  = 4'd1,
      ST_MEMADR  = 4'd2,
      ST_MEMRD   = 4'd3,
      ST_MEMWB   = 4'd4,
      ST_MEMWR   = 4'd5,
      ST_EXEC_R  = 4'd6,
      ST_ALUWB_R = 4'd7,
      ST_EXEC_I  = 4'd8,
      ST_ALUWB_I = 4'd9,
      ST_BRANCH  = 4'd10,
      ST_JUMP    = 4'd11
   } state_e;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       illegal_op;
      logic       mem_err;
   } ctrl_t;

   function automatic logic is_itype(input logic [5:0] op);
      return op inside {EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI,
                        EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU};
   endfunction

   function automatic logic op_is_legal(input logic [5:0] op);
      return is_itype(op) || (op inside {EXE_RTYPE, EXE_J, EXE_BEQ, EXE_LW, EXE_SW});
   endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// -----------------------------------------------------------------------------
// mc_ctrl_outdec
// Combinational output decoder: current state plus memory handshake -> control
// word.
//   state     : current FSM state
//   mem_ready : memory completes this cycle (only meaningful in FETCH)
//   timeout   : wait limit hit in a memory state with mem_ready low
//   illegal   : opcode presented in DECODE is not recognised
//   ctrl      : full control word
// -----------------------------------------------------------------------------
module mc_ctrl_outdec
   import mc_controller_pkg::*;
(
   input  state_e state,
   input  logic   mem_ready,
   input  logic   timeout,
   input  logic   illegal,
   output ctrl_t  ctrl
);

   always_comb begin
      // NOTE: default the whole word first so every path assigns every field;
      // anything not set below is 0 and no latch is inferred.
      ctrl = '0;
      unique case (state)
         ST_FETCH: begin
            ctrl.mem_req = 1'b1;
            ctrl.alusrcb = 2'b01;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
            ctrl.mem_err = timeout;
         end
         ST_DECODE: begin
            ctrl.alusrcb    = 2'b11;
            ctrl.illegal_op = illegal;
         end
         ST_MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = 2'b10;
         end
         ST_MEMRD: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
            ctrl.mem_err = timeout;
         end
         ST_MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         ST_MEMWR: begin
            ctrl.mem_req  = 1'b1;
            ctrl.iord     = 1'b1;
            // An aborted write must not be committed.
            ctrl.memwrite = !timeout;
            ctrl.mem_err  = timeout;
         end
         ST_EXEC_R: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = 2'b10;
         end
         ST_ALUWB_R: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
         end
         ST_EXEC_I: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = 2'b10;
            ctrl.aluop   = 2'b11;
         end
         ST_ALUWB_I: begin
            ctrl.regwrite = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = 2'b01;
            ctrl.pcsrc   = 2'b01;
            ctrl.branch  = 1'b1;
         end
         ST_JUMP: begin
            ctrl.pcsrc   = 2'b10;
            ctrl.pcwrite = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multicycle MIPS-style control FSM with a bounded memory-wait watchdog.
//   clk, rst        : clock, synchronous active-high reset
//   op              : opcode from IR, used in DECODE and MEMADR
//   mem_ready       : memory completes current request
//   mem_req .. pcsrc: datapath controls
//   illegal_op      : one-cycle pulse on unknown opcode
//   mem_err         : one-cycle pulse on memory wait timeout
//   state           : current state, for debug
// -----------------------------------------------------------------------------
module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state
);

   localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] wait_q;
   logic          mem_state, timeout;
   ctrl_t         ctrl, ctrl_out;

   assign mem_state = state_q inside {ST_FETCH, ST_MEMRD, ST_MEMWR};
   assign timeout   = mem_state && !mem_ready && (wait_q == CW'(MEM_WAIT_MAX));

   // State register
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   // Wait counter: counts stalled memory cycles; a state change only happens on
   // completion or timeout, both of which clear it.
   always_ff @(posedge clk) begin
      if (rst)                                     wait_q <= '0;
      else if (mem_state && !mem_ready && !timeout) wait_q <= wait_q + 1'b1;
      else                                         wait_q <= '0;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_FETCH: begin
            if (mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (op == EXE_LW || op == EXE_SW) state_d = ST_MEMADR;
            else if (op == EXE_RTYPE)         state_d = ST_EXEC_R;
            else if (is_itype(op))            state_d = ST_EXEC_I;
            else if (op == EXE_BEQ)           state_d = ST_BRANCH;
            else if (op == EXE_J)             state_d = ST_JUMP;
            else                              state_d = ST_FETCH;
         end
         ST_MEMADR:  state_d = (op == EXE_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD: begin
            if (mem_ready)    state_d = ST_MEMWB;
            else if (timeout) state_d = ST_FETCH;
         end
         ST_MEMWR: begin
            if (mem_ready || timeout) state_d = ST_FETCH;
         end
         ST_EXEC_R:  state_d = ST_ALUWB_R;
         ST_EXEC_I:  state_d = ST_ALUWB_I;
         default:    state_d = ST_FETCH;
      endcase
   end

   // Output logic
   mc_ctrl_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .timeout   (timeout),
      .illegal   (!op_is_legal(op)),
      .ctrl      (ctrl)
   );

   // Reset forces every output low on the very first reset cycle, before the
   // state register has been cleared.
   assign ctrl_out   = rst ? '0 : ctrl;
   assign state      = rst ? ST_FETCH : state_q;

   assign mem_req    = ctrl_out.mem_req;
   assign iord       = ctrl_out.iord;
   assign memwrite   = ctrl_out.memwrite;
   assign irwrite    = ctrl_out.irwrite;
   assign pcwrite    = ctrl_out.pcwrite;
   assign branch     = ctrl_out.branch;
   assign regwrite   = ctrl_out.regwrite;
   assign regdst     = ctrl_out.regdst;
   assign memtoreg   = ctrl_out.memtoreg;
   assign alusrca    = ctrl_out.alusrca;
   assign alusrcb    = ctrl_out.alusrcb;
   assign aluop      = ctrl_out.aluop;
   assign pcsrc      = ctrl_out.pcsrc;
   assign illegal_op = ctrl_out.illegal_op;
   assign mem_err    = ctrl_out.mem_err;

endmodule
